// File: rtl/hba_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// hba_rr_arbiter_if
// Bus-side signals between the HBA masters/slaves and the round-robin arbiter.
//
// Signals:
//   hba_mrequest[3:0]  per-master bus request, bit n = master n
//   hba_select         OR-ed bus select; a transfer is in progress
//   hba_xferack        OR-ed slave transfer acknowledge
//   hba_mgrant[3:0]    one-hot-or-zero grant, bit n = master n
//   hba_timeout_ack    watchdog-generated acknowledge; the top level ORs it
//                      into hba_xferack
//
// Modports:
//   master  bus side: drives request/select/xferack, observes grant/timeout
//   slave   arbiter side: observes request/select/xferack, drives grant/timeout
//
// Handshake: a master owns the bus from the cycle its hba_mgrant bit is seen
// high until the arbiter drops it; the arbiter keeps the grant while the
// owner's request or hba_select is high and releases it on the first edge
// where both are low.
// ---------------------------------------------------------------------------
interface hba_rr_arbiter_if;
    logic [3:0] hba_mrequest;
    logic       hba_select;
    logic       hba_xferack;
    logic [3:0] hba_mgrant;
    logic       hba_timeout_ack;

    modport master (
        output hba_mrequest,
        output hba_select,
        output hba_xferack,
        input  hba_mgrant,
        input  hba_timeout_ack
    );

    modport slave (
        input  hba_mrequest,
        input  hba_select,
        input  hba_xferack,
        output hba_mgrant,
        output hba_timeout_ack
    );
endinterface

// File: rtl/hba_rr_arbiter.sv
// ---------------------------------------------------------------------------
// hba_rr_arbiter
// Four-master round-robin bus arbiter with an optional select watchdog.
//
// Build option:
//   HBA_ARB_TIMEOUT_EN  when defined, an 8-bit watchdog counts select cycles
//                       without hba_xferack and fires hba_timeout_ack after
//                       TIMEOUT_CYCLES such cycles. When undefined, the
//                       watchdog outputs are tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES      select cycles without xferack before the watchdog
//                       fires (2..255)
//
// Ports:
//   hba_clk             single clock, rising edge
//   hba_reset           synchronous active-high reset
//   bus (slave)         request/select/xferack in, grant/timeout_ack out
//   timeout_clr         one-cycle pulse clearing timeout_flag
//   arb_busy            high while a grant is asserted
//   arb_owner[1:0]      index of the granted master; holds last owner when idle
//   timeout_flag        sticky watchdog-fired indication
//   timeout_master[1:0] arb_owner captured at the last watchdog event
//   o_dbg_state[1:0]    current arbitration state (0 IDLE, 1 GRANT, 2 RELEASE)
//
// All outputs are registered. A grant appears one cycle after a request is
// seen in IDLE; after a release there are exactly two zero-grant cycles
// (RELEASE, then the IDLE evaluation cycle) before the next grant.
// ---------------------------------------------------------------------------
module hba_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             hba_clk,
    input  logic             hba_reset,
    hba_rr_arbiter_if.slave  bus,
    input  logic             timeout_clr,
    output logic             arb_busy,
    output logic [1:0]       arb_owner,
    output logic             timeout_flag,
    output logic [1:0]       timeout_master,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_grant;
    logic       r_busy;
    logic [1:0] r_owner;
    logic [1:0] r_last;

    state_t     w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_owner_nxt;
    logic [1:0] w_last_nxt;
    logic [1:0] w_rr_win;
    logic       w_rr_found;

    // Round-robin pick: scan last+1, last+2, ... with 2-bit wrap; the first
    // requesting master wins. Only meaningful when some request is set.
    always_comb begin
        w_rr_win   = r_last;
        w_rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_rr_found && bus.hba_mrequest[r_last + 2'(i)]) begin
                w_rr_win   = r_last + 2'(i);
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 4'b0000;
                if (w_rr_found) begin
                    w_grant_nxt = 4'b0001 << w_rr_win;
                    w_owner_nxt = w_rr_win;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Other masters' requests are ignored; the owner keeps the bus
                // until both its request and select are low.
                if (!(bus.hba_mrequest[r_owner] || bus.hba_select)) begin
                    w_grant_nxt = 4'b0000;
                    w_last_nxt  = r_owner;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_grant_nxt = 4'b0000;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = 4'b0000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset takes priority over any grant, so a mid-grant reset drops the
    // grant at that edge without passing through RELEASE.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= |w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.hba_mgrant = r_grant;
    assign arb_busy       = r_busy;
    assign arb_owner      = r_owner;
    assign o_dbg_state    = r_state;

`ifdef HBA_ARB_TIMEOUT_EN
    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wd_cnt;
    logic       r_wd_ack;
    logic       r_wd_flag;
    logic [1:0] r_wd_master;
    logic       w_wd_inc;
    logic       w_wd_fire;

    // An xferack in the limit cycle makes w_wd_inc false, which is what
    // suppresses a timeout racing a late acknowledge.
    assign w_wd_inc  = bus.hba_select && !bus.hba_xferack;
    assign w_wd_fire = w_wd_inc && (r_wd_cnt == LP_LIMIT);

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_wd_cnt    <= 8'd0;
            r_wd_ack    <= 1'b0;
            r_wd_flag   <= 1'b0;
            r_wd_master <= 2'd0;
        end else begin
            r_wd_ack <= w_wd_fire;
            if (w_wd_fire || !w_wd_inc) begin
                r_wd_cnt <= 8'd0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
            // A watchdog event wins over a simultaneous clear.
            if (w_wd_fire) begin
                r_wd_flag <= 1'b1;
            end else if (timeout_clr) begin
                r_wd_flag <= 1'b0;
            end
            if (w_wd_fire) begin
                r_wd_master <= r_owner;
            end
        end
    end

    assign bus.hba_timeout_ack = r_wd_ack;
    assign timeout_flag        = r_wd_flag;
    assign timeout_master      = r_wd_master;
`else
    // Watchdog not built: inputs that only feed it are collected here.
    logic w_unused_cfg;
    assign w_unused_cfg = &{1'b0, timeout_clr, bus.hba_xferack, 8'(TIMEOUT_CYCLES)};

    assign bus.hba_timeout_ack = 1'b0;
    assign timeout_flag        = 1'b0;
    assign timeout_master      = 2'd0;
`endif

endmodule

// File: tb/tb_hba_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hba_rr_arbiter
// Directed bench for hba_rr_arbiter. A cycle-level behavioural model tracks
// "who holds the bus" and "is a turnaround pending" and is compared against
// the DUT every cycle; hand-computed literal checks pin the model. Watchdog
// expectations follow whether HBA_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hba_rr_arbiter;

    localparam int T = 4;

`ifdef HBA_ARB_TIMEOUT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    hba_rr_arbiter_if bus_if ();

    logic       busy;
    logic [1:0] owner;
    logic       flag;
    logic [1:0] tmaster;
    logic [1:0] dbg_state;

    hba_rr_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .hba_clk        (clk),
        .hba_reset      (rst),
        .bus            (bus_if.slave),
        .timeout_clr    (clr),
        .arb_busy       (busy),
        .arb_owner      (owner),
        .timeout_flag   (flag),
        .timeout_master (tmaster),
        .o_dbg_state    (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_hold: master currently holding the bus, -1 if none.
    // m_turn: a release just happened, so the next cycle cannot grant.
    int         m_hold = -1;
    bit         m_turn = 1'b0;
    int         m_last = 3;
    int         m_owner = 0;
    logic [3:0] m_grant = 4'b0000;
    int         m_cnt = 0;
    bit         m_ack = 1'b0;
    bit         m_flag = 1'b0;
    int         m_tmaster = 0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_hold = -1; m_turn = 1'b0; m_last = 3; m_owner = 0;
            m_cnt = 0; m_ack = 1'b0; m_flag = 1'b0; m_tmaster = 0;
            m_valid = 1'b1;
        end else begin
            if (EN) begin
                m_ack = 1'b0;
                if (bus_if.hba_select && !bus_if.hba_xferack) begin
                    if (m_cnt == T - 1) begin
                        m_ack = 1'b1; m_cnt = 0; m_tmaster = m_owner;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_cnt = 0;
                end
                if (m_ack) m_flag = 1'b1;
                else if (clr) m_flag = 1'b0;
            end
            if (m_hold >= 0) begin
                if (!(bus_if.hba_mrequest[m_hold] || bus_if.hba_select)) begin
                    m_last = m_hold; m_hold = -1; m_turn = 1'b1;
                end
            end else if (m_turn) begin
                m_turn = 1'b0;
            end else if (bus_if.hba_mrequest != 4'b0000) begin
                for (int i = 1; i <= 4; i++) begin
                    if (m_hold < 0 && bus_if.hba_mrequest[(m_last + i) % 4]) m_hold = (m_last + i) % 4;
                end
                m_owner = m_hold;
            end
        end
        m_grant = (m_hold >= 0) ? (4'b0001 << m_hold) : 4'b0000;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_grant", bus_if.hba_mgrant, m_grant);
            chk("cyc_busy", busy, m_grant != 4'b0000);
            chk("cyc_owner", owner, m_owner);
            chk("cyc_onehot", $onehot0(bus_if.hba_mgrant), 1);
            chk("cyc_ack", bus_if.hba_timeout_ack, m_ack);
            chk("cyc_flag", flag, m_flag);
            chk("cyc_tmaster", tmaster, m_tmaster);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 4;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Scoreboard: expected grant order for the all-request rotation.
    logic [1:0] exp_q[$];

    // ---------------- directed sequence ----------------
    initial begin
        int zeros;
        int o;
        rst = 1'b1; clr = 1'b0;
        bus_if.hba_mrequest = 4'b0000;
        bus_if.hba_select   = 1'b0;
        bus_if.hba_xferack  = 1'b0;
        tick(2);
        chk("rst_grant", bus_if.hba_mgrant, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ack", bus_if.hba_timeout_ack, 0);
        chk("rst_flag", flag, 0);
        chk("rst_tmaster", tmaster, 0);
        rst = 1'b0;
        tick(1);
        chk("idle_grant", bus_if.hba_mgrant, 4'b0000);

        // single request from master 0: one-cycle latency
        bus_if.hba_mrequest = 4'b0001;
        tick(1);
        chk("m0_grant", bus_if.hba_mgrant, 4'b0001);
        chk("m0_owner", owner, 0);
        chk("m0_busy", busy, 1);
        bus_if.hba_mrequest = 4'b0000;
        tick(1);
        chk("m0_release", bus_if.hba_mgrant, 4'b0000);
        chk("m0_owner_hold", owner, 0);
        tick(1);

        // back to master-0-first priority, then full rotation
        rst = 1'b1; tick(1); rst = 1'b0;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus_if.hba_mrequest = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                zeros = 0;
                while (bus_if.hba_mgrant == 4'b0000 && zeros < 20) begin
                    zeros++;
                    tick(1);
                end
                chk("rr_gap", zeros, 2);
            end
            o = idx_of(bus_if.hba_mgrant);
            chk("rr_order", o, exp_q.pop_front());
            bus_if.hba_select = 1'b1; bus_if.hba_xferack = 1'b1;
            tick(1);
            bus_if.hba_select = 1'b0; bus_if.hba_xferack = 1'b0;
            if (o < 4) bus_if.hba_mrequest[o] = 1'b0;
            tick(1);
            chk("rr_release", bus_if.hba_mgrant, 4'b0000);
            if (k < 4 && o < 4) bus_if.hba_mrequest[o] = 1'b1;
            else bus_if.hba_mrequest = 4'b0000;
        end
        tick(2);

        // owner 2 drops request while select stays high for 3 cycles
        bus_if.hba_mrequest = 4'b0100;
        tick(1);
        chk("sel_grant", bus_if.hba_mgrant, 4'b0100);
        bus_if.hba_select = 1'b1; bus_if.hba_mrequest = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("sel_hold", bus_if.hba_mgrant, 4'b0100);
        end
        bus_if.hba_select = 1'b0;
        tick(1);
        chk("sel_release", bus_if.hba_mgrant, 4'b0000);
        tick(1);

        // watchdog: owner 1 holds select with no xferack
        bus_if.hba_mrequest = 4'b0010;
        tick(1);
        chk("wd_grant", bus_if.hba_mgrant, 4'b0010);
        chk("wd_owner", owner, 1);
        bus_if.hba_select = 1'b1;
        tick(3);
        chk("wd_ack_early", bus_if.hba_timeout_ack, 0);
        tick(1);
        chk("wd_ack", bus_if.hba_timeout_ack, EN);
        chk("wd_flag", flag, EN);
        chk("wd_tmaster", tmaster, EN ? 1 : 0);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("wd_ack_pulse", bus_if.hba_timeout_ack, 0);
        chk("wd_flag_clr", flag, 0);
        tick(2);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("wd_ack2", bus_if.hba_timeout_ack, EN);
        chk("wd_flag_simul", flag, EN);
        bus_if.hba_select = 1'b0; bus_if.hba_mrequest = 4'b0000;
        tick(1);
        chk("wd_release", bus_if.hba_mgrant, 4'b0000);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("wd_flag_clr2", flag, 0);
        tick(1);

        // xferack in the 4th select cycle suppresses the timeout
        bus_if.hba_mrequest = 4'b0100;
        tick(1);
        chk("sup_grant", bus_if.hba_mgrant, 4'b0100);
        bus_if.hba_select = 1'b1;
        tick(3);
        bus_if.hba_xferack = 1'b1;
        tick(1);
        chk("sup_ack", bus_if.hba_timeout_ack, 0);
        bus_if.hba_xferack = 1'b0; bus_if.hba_select = 1'b0; bus_if.hba_mrequest = 4'b0000;
        tick(1);
        chk("sup_ack2", bus_if.hba_timeout_ack, 0);
        chk("sup_flag", flag, 0);
        tick(1);

        // reset during master 3's grant
        bus_if.hba_mrequest = 4'b1000;
        tick(1);
        chk("r3_grant", bus_if.hba_mgrant, 4'b1000);
        chk("r3_owner", owner, 3);
        rst = 1'b1;
        tick(1);
        chk("r3_drop", bus_if.hba_mgrant, 4'b0000);
        chk("r3_owner_rst", owner, 0);
        rst = 1'b0;
        tick(1);
        chk("r3_regrant", bus_if.hba_mgrant, 4'b1000);
        chk("r3_owner2", owner, 3);
        chk("r3_busy", busy, 1);
        bus_if.hba_mrequest = 4'b0000;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hba_rr_arbiter.md
HBA_RR_ARBITER -- requirements
Module: hba_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 2..255: select cycles without xferack before the watchdog fires.
REQ-002 hba_clk  input  1  single clock; all logic rising-edge.
REQ-003 hba_reset  input  1  synchronous, active-high reset.
REQ-004 hba_mrequest  input  4  per-master bus request, bit n = master n.
REQ-005 hba_select  input  1  OR-ed bus select; transfer in progress.
REQ-006 hba_xferack  input  1  OR-ed slave transfer acknowledge.
REQ-007 timeout_clr  input  1  one-cycle pulse; clears timeout_flag.
REQ-008 hba_mgrant  output  4  one-hot-or-zero grant, bit n = master n.
REQ-009 arb_busy  output  1  high while any grant is asserted.
REQ-010 arb_owner  output  2  index of the granted master; holds the last owner when idle.
REQ-011 hba_timeout_ack  output  1  watchdog-generated acknowledge; top level ORs it into hba_xferack.
REQ-012 timeout_flag  output  1  sticky watchdog-fired indication.
REQ-013 timeout_master  output  2  arb_owner captured at the last watchdog event.

Function
REQ-014 All outputs SHALL be registered; hba_mgrant SHALL never have more than one bit set.
REQ-015 FSM states: IDLE (grant 0), GRANT (one bit set), RELEASE (grant 0, exactly one cycle).
REQ-016 IDLE: if hba_mrequest != 0, select the winner by round-robin; assert its grant and arb_owner next cycle; go to GRANT. Request-to-grant latency: 1 cycle.
REQ-017 Round-robin: search from (last_owner+1) mod 4 upward with wrap; first requesting master wins.
REQ-018 GRANT: hold the grant while hba_mrequest[owner]=1 OR hba_select=1; ignore all other requests.
REQ-019 GRANT: when hba_mrequest[owner]=0 AND hba_select=0 at an edge, clear the grant, update last_owner to the owner, go to RELEASE.
REQ-020 RELEASE: always go to IDLE, giving a guaranteed one-cycle bus turnaround; back-to-back grants to different masters are spaced by exactly two zero-grant cycles (RELEASE, then IDLE evaluation).
REQ-021 A requester whose request drops while hba_select=1 SHALL keep its grant until select falls.
REQ-022 Watchdog counter (8-bit): increments each cycle with hba_select=1 and hba_xferack=0; clears when hba_select=0 or hba_xferack=1.
REQ-023 When the counter equals TIMEOUT_CYCLES-1 with the increment condition true, the next cycle SHALL set hba_timeout_ack=1 for exactly one cycle, set timeout_flag, load timeout_master=arb_owner, and clear the counter.
REQ-024 timeout_flag SHALL clear on timeout_clr; a simultaneous timeout_clr and watchdog event SHALL leave the flag set.
REQ-025 hba_xferack arriving in the same cycle the counter reaches the limit SHALL suppress the timeout.

Reset
REQ-026 On reset: state IDLE, hba_mgrant=0, arb_busy=0, arb_owner=0, last_owner=3 (master 0 has first priority), counter=0, hba_timeout_ack=0, timeout_flag=0, timeout_master=0.
REQ-027 Reset asserted mid-grant SHALL drop the grant at that edge; no RELEASE cycle is required.

Configuration
REQ-028 Macro HBA_ARB_TIMEOUT_EN defined: watchdog per REQ-022..REQ-025 is compiled in.
REQ-029 Macro undefined: no counter; hba_timeout_ack, timeout_flag and timeout_master are tied to 0; ports remain; arbitration is unchanged.

Verification
REQ-030 Reset, then mrequest=4'b0001 -> mgrant=4'b0001 one cycle later, arb_owner=0, arb_busy=1.
REQ-031 mrequest=4'b1111 held; each owner drops its request after one transfer -> grant order 0,1,2,3,0 with two zero-grant cycles between grants.
REQ-032 Owner 2 drops its request while hba_select=1 for 3 more cycles -> grant 4'b0100 held until select falls, then RELEASE.
REQ-033 (EN) TIMEOUT_CYCLES=4, owner 1 holds select, no xferack -> hba_timeout_ack pulses on the 5th cycle of select, timeout_flag=1, timeout_master=1; timeout_clr -> flag=0.
REQ-034 (EN) xferack on the 4th select cycle with TIMEOUT_CYCLES=4 -> no hba_timeout_ack, flag stays 0.
REQ-035 Reset pulsed during the grant to master 3 -> mgrant=0 the next cycle; the subsequent request from master 3 is granted first (last_owner=3 after reset, so the search starts at master 0 and master 3 is the only requester).
